// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, common command bytes, parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // Bit that makes the total count of ones across data+parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data lines plus a falling-edge pulse on the clock.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_raw,
  input  logic data_raw,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);

  logic [1:0] clk_meta;
  logic [1:0] data_meta;
  logic       clk_prev;

  // Reset to the idle (pulled-up) level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 2'b11;
      data_meta <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_meta  <= {clk_meta[0], clk_raw};
      data_meta <= {data_meta[0], data_raw};
      clk_prev  <= clk_meta[1];
    end
  end

  assign clk_s    = clk_meta[1];
  assign data_s   = data_meta[1];
  assign clk_fall = clk_prev & ~clk_meta[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, start, 8 data LSB-first, odd parity, stop, device ACK.
//
// state     | meaning
// IDLE      | lines released, ready for a command byte
// INHIBIT   | ps2_clk held low; start bit asserted on the final cycle
// SEND      | device clocks out start/data/parity; stop released on the 10th fall
// ACK       | sample the device ACK on the next clock fall
// WAIT_IDLE | wait for both lines high, then report done
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);

  ps2_state_t       state_q, state_d;
  logic [9:0]       shreg_q, shreg_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             ack_ok_r_q, ack_ok_r_d;
  logic             ack_ok_q, ack_ok_d;

  logic clk_s, data_s, clk_fall;
  logic tmo_hit;

  ps2_line_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .clk_raw  (ps2_clk_i),
    .data_raw (ps2_data_i),
    .clk_s    (clk_s),
    .data_s   (data_s),
    .clk_fall (clk_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      inh_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      ack_ok_r_q <= 1'b0;
      ack_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      inh_cnt_q  <= inh_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      ack_ok_r_q <= ack_ok_r_d;
      ack_ok_q   <= ack_ok_d;
    end
  end

  // Frame timeout runs from SEND entry and is never restarted by clock falls.
  assign tmo_hit = (state_q inside {SEND, ACK, WAIT_IDLE}) && (tmo_cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    inh_cnt_d   = inh_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    ack_ok_r_d  = ack_ok_r_q;
    ack_ok_d    = ack_ok_q;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    done        = 1'b0;
    err_timeout = 1'b0;

    if (tmo_hit) begin
      err_timeout = 1'b1;
      state_d     = IDLE;
    end else begin
      if (state_q inside {SEND, ACK, WAIT_IDLE}) begin
        tmo_cnt_d = tmo_cnt_q - 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (tx_valid) begin
            shreg_d   = {1'b1, odd_parity(tx_data), tx_data};
            bitcnt_d  = '0;
            inh_cnt_d = INH_LOAD;
            state_d   = INHIBIT;
          end
        end
        INHIBIT: begin
          ps2_clk_oe = 1'b1;
          if (inh_cnt_q == '0) begin
            ps2_data_oe = 1'b1;
            tmo_cnt_d   = TMO_LOAD;
            state_d     = SEND;
          end else begin
            inh_cnt_d = inh_cnt_q - 1'b1;
          end
        end
        SEND: begin
          // Start bit stays on the wire until the first device fall, then data bit 0.
          ps2_data_oe = (bitcnt_q == 4'd0) ? 1'b1 : ~shreg_q[0];
          if (clk_fall) begin
            if (bitcnt_q == 4'd9) begin
              bitcnt_d = 4'd10;
              state_d  = ACK;
            end else begin
              bitcnt_d = bitcnt_q + 4'd1;
              if (bitcnt_q != 4'd0) begin
                shreg_d = {1'b0, shreg_q[9:1]};
              end
            end
          end
        end
        ACK: begin
          if (clk_fall) begin
            ack_ok_r_d = ~data_s;
            state_d    = WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (clk_s && data_s) begin
            done     = 1'b1;
            ack_ok_d = ack_ok_r_q;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign tx_ready   = (state_q == IDLE);
  assign rx_inhibit = (state_q != IDLE);
  assign ack_ok     = done ? ack_ok_r_q : ack_ok_q;

endmodule
